parking_gate_controller: RTL and testbench

Sequencing controller for the four-spot parking module. It owns the occupancy vector that feeds the empty-spot counter and arbitrates between the entry and exit gates. It allocates the lowest free spot to arriving cars, frees spots on exit, and holds the shared barrier open for a fixed number of cycles per event. One gate event is serviced at a time; exit requests win over entry requests.

---
 rtl/parking_gate_controller.sv | 122 ++++++++++++
 tb/tb_parking_gate_controller.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_controller.sv
// rtl/parking_gate_controller.sv - four-spot parking gate sequencer with occupancy tracking
module parking_gate_controller #(
  parameter int GATE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic [1:0] exit_spot,
  output logic       entry_grant,
  output logic [1:0] entry_spot,
  output logic       exit_ack,
  output logic       exit_err,
  output logic       gate_open,
  output logic [3:0] parked,
  output logic [2:0] empty,
  output logic       full
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ENTRY_GATE = 2'd1,
    EXIT_GATE  = 2'd2
  } state_t;

  // Counter starts one below the cycle count so the gate is high for exactly GATE_CYCLES cycles.
  localparam logic [3:0] GATE_LOAD = 4'(GATE_CYCLES - 1);

  state_t     state;
  state_t     state_nx;
  logic [3:0] gate_cnt;
  logic [3:0] gate_cnt_nx;
  logic [3:0] parked_nx;
  logic [1:0] entry_spot_nx;
  logic       entry_grant_nx;
  logic       exit_ack_nx;
  logic       exit_err_nx;
  logic [1:0] free_idx;
  logic [2:0] occupied;

  // Lowest-index free spot; only meaningful when the lot is not full.
  always_comb begin
    free_idx = 2'd0;
    if (!parked[0])      free_idx = 2'd0;
    else if (!parked[1]) free_idx = 2'd1;
    else if (!parked[2]) free_idx = 2'd2;
    else                 free_idx = 2'd3;
  end

  // Occupancy-derived status, straight from the registered vector.
  always_comb begin
    occupied = {2'b00, parked[0]} + {2'b00, parked[1]} + {2'b00, parked[2]} + {2'b00, parked[3]};
  end

  assign empty     = 3'd4 - occupied;
  assign full      = (parked == 4'b1111);
  assign gate_open = (state != IDLE);

  // Next-state and next-output decision: exit beats entry, gate states ignore requests.
  always_comb begin
    state_nx       = state;
    gate_cnt_nx    = gate_cnt;
    parked_nx      = parked;
    entry_spot_nx  = entry_spot;
    entry_grant_nx = 1'b0;
    exit_ack_nx    = 1'b0;
    exit_err_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (exit_req) begin
          if (parked[exit_spot]) begin
            parked_nx   = parked & ~(4'b0001 << exit_spot);
            exit_ack_nx = 1'b1;
            gate_cnt_nx = GATE_LOAD;
            state_nx    = EXIT_GATE;
          end else begin
            // Bad exit index: report it without opening the gate or touching occupancy.
            exit_err_nx = 1'b1;
          end
        end else if (entry_req && !full) begin
          parked_nx      = parked | (4'b0001 << free_idx);
          entry_spot_nx  = free_idx;
          entry_grant_nx = 1'b1;
          gate_cnt_nx    = GATE_LOAD;
          state_nx       = ENTRY_GATE;
        end
      end
      ENTRY_GATE, EXIT_GATE: begin
        if (gate_cnt == 4'd0) begin
          state_nx = IDLE;
        end else begin
          gate_cnt_nx = gate_cnt - 4'd1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, counter, occupancy and pulse registers; reset wipes the occupancy vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gate_cnt    <= 4'd0;
      parked      <= 4'b0000;
      entry_spot  <= 2'd0;
      entry_grant <= 1'b0;
      exit_ack    <= 1'b0;
      exit_err    <= 1'b0;
    end else begin
      state       <= state_nx;
      gate_cnt    <= gate_cnt_nx;
      parked      <= parked_nx;
      entry_spot  <= entry_spot_nx;
      entry_grant <= entry_grant_nx;
      exit_ack    <= exit_ack_nx;
      exit_err    <= exit_err_nx;
    end
  end

endmodule

// File: tb/tb_parking_gate_controller.sv
// tb/tb_parking_gate_controller.sv - directed scoreboard bench for parking_gate_controller
module tb_parking_gate_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       entry_req;
  logic       exit_req;
  logic [1:0] exit_spot;
  logic       entry_grant;
  logic [1:0] entry_spot;
  logic       exit_ack;
  logic       exit_err;
  logic       gate_open;
  logic [3:0] parked;
  logic [2:0] empty;
  logic       full;

  int total = 0;
  int bad   = 0;

  // Event word: {grant, ack, err, spot (grant only), parked after the event}.
  logic [8:0] sb[$];
  logic [8:0] mon_obs;
  logic [8:0] mon_exp;

  parking_gate_controller #(.GATE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .entry_req   (entry_req),
    .exit_req    (exit_req),
    .exit_spot   (exit_spot),
    .entry_grant (entry_grant),
    .entry_spot  (entry_spot),
    .exit_ack    (exit_ack),
    .exit_err    (exit_err),
    .gate_open   (gate_open),
    .parked      (parked),
    .empty       (empty),
    .full        (full)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] ev(input logic g, input logic a, input logic e,
                                    input logic [1:0] sp, input logic [3:0] pk);
    return {g, a, e, sp, pk};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // which: 0 entry_grant, 1 exit_ack, 2 exit_err, 3 gate closed
  task automatic wait_sig(input int which, input int budget, input string tag, output int waited);
    logic hit;
    hit = 1'b0;
    waited = 0;
    while (!hit && waited < budget) begin
      @(negedge clk);
      waited++;
      case (which)
        0: hit = entry_grant;
        1: hit = exit_ack;
        2: hit = exit_err;
        default: hit = !gate_open;
      endcase
    end
    check(tag, {31'd0, hit}, 32'd1);
  endtask

  // Every response pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (entry_grant || exit_ack || exit_err) begin
      mon_obs = {entry_grant, exit_ack, exit_err, (entry_grant ? entry_spot : 2'b00), parked};
      check("pulse_was_expected", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (sb.size() > 0) begin
        mon_exp = sb.pop_front();
        check("event", {23'd0, mon_obs}, {23'd0, mon_exp});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int gcnt;
    int grants;
    int gidx[4];

    rst = 1'b1;
    entry_req = 1'b0;
    exit_req = 1'b0;
    exit_spot = 2'd0;
    repeat (2) @(negedge clk);
    check("rst_parked", parked, 4'b0000);
    check("rst_empty", empty, 3'd4);
    check("rst_full", full, 1'b0);
    check("rst_gate", gate_open, 1'b0);
    check("rst_pulses", {entry_grant, exit_ack, exit_err}, 3'b000);
    check("rst_entry_spot", entry_spot, 2'd0);
    rst = 1'b0;

    // Four back-to-back entries.
    for (int k = 0; k < 4; k++) sb.push_back(ev(1'b1, 1'b0, 1'b0, 2'(k), 4'((1 << (k + 1)) - 1)));
    entry_req = 1'b1;
    grants = 0;
    gcnt = 0;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      if (gate_open) gcnt++;
      if (entry_grant) begin
        check("t1_empty", empty, 32'(3 - grants));
        if (grants < 4) gidx[grants] = i;
        grants++;
        if (grants == 4) entry_req = 1'b0;
      end
    end
    check("t1_grants", grants, 4);
    check("t1_first_lat", gidx[0], 1);
    for (int i = 1; i < 4; i++) check("t1_spacing", gidx[i] - gidx[i-1], 5);
    check("t1_gate_cycles", gcnt, 16);
    check("t1_full", full, 1'b1);
    check("t1_empty_end", empty, 3'd0);

    // Full lot: held entry gets nothing until an exit frees spot 2.
    entry_req = 1'b1;
    gcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (gate_open) gcnt++;
    end
    check("t2_gate_while_full", gcnt, 0);
    sb.push_back(ev(1'b0, 1'b1, 1'b0, 2'd0, 4'b1011));
    sb.push_back(ev(1'b1, 1'b0, 1'b0, 2'd2, 4'b1111));
    exit_spot = 2'd2;
    exit_req = 1'b1;
    wait_sig(1, 5, "t2_ack_seen", w);
    exit_req = 1'b0;
    check("t2_ack_lat", w, 1);
    check("t2_parked", parked, 4'b1011);
    check("t2_gate_on_ack", gate_open, 1'b1);
    wait_sig(0, 10, "t2_grant_seen", w);
    entry_req = 1'b0;
    check("t2_grant_spacing", w, 5);
    check("t2_entry_spot", entry_spot, 2'd2);

    // Move to parked=0101.
    sb.push_back(ev(1'b0, 1'b1, 1'b0, 2'd0, 4'b1101));
    exit_spot = 2'd1;
    exit_req = 1'b1;
    wait_sig(1, 10, "t3_setup_ack1", w);
    exit_req = 1'b0;
    sb.push_back(ev(1'b0, 1'b1, 1'b0, 2'd0, 4'b0101));
    exit_spot = 2'd3;
    exit_req = 1'b1;
    wait_sig(1, 10, "t3_setup_ack3", w);
    exit_req = 1'b0;
    wait_sig(3, 10, "t3_gate_closed", w);

    // Exit of an empty spot.
    sb.push_back(ev(1'b0, 1'b0, 1'b1, 2'd0, 4'b0101));
    exit_spot = 2'd1;
    exit_req = 1'b1;
    wait_sig(2, 5, "t3_err_seen", w);
    exit_req = 1'b0;
    check("t3_err_lat", w, 1);
    check("t3_parked", parked, 4'b0101);
    check("t3_gate", gate_open, 1'b0);
    @(negedge clk);
    check("t3_err_one_cycle", exit_err, 1'b0);
    check("t3_gate_after", gate_open, 1'b0);

    // Move to parked=0001, then simultaneous exit and entry.
    sb.push_back(ev(1'b0, 1'b1, 1'b0, 2'd0, 4'b0001));
    exit_spot = 2'd2;
    exit_req = 1'b1;
    wait_sig(1, 5, "t4_setup_ack", w);
    exit_req = 1'b0;
    wait_sig(3, 10, "t4_gate_closed", w);
    sb.push_back(ev(1'b0, 1'b1, 1'b0, 2'd0, 4'b0000));
    sb.push_back(ev(1'b1, 1'b0, 1'b0, 2'd0, 4'b0001));
    exit_spot = 2'd0;
    exit_req = 1'b1;
    entry_req = 1'b1;
    wait_sig(1, 5, "t4_ack_seen", w);
    exit_req = 1'b0;
    check("t4_ack_lat", w, 1);
    check("t4_parked", parked, 4'b0000);
    wait_sig(0, 10, "t4_grant_seen", w);
    entry_req = 1'b0;
    check("t4_grant_spacing", w, 5);
    check("t4_entry_spot", entry_spot, 2'd0);

    // Reset in the second cycle of an entry gate with parked=0111.
    sb.push_back(ev(1'b1, 1'b0, 1'b0, 2'd1, 4'b0011));
    sb.push_back(ev(1'b1, 1'b0, 1'b0, 2'd2, 4'b0111));
    entry_req = 1'b1;
    wait_sig(0, 10, "t5_grant1", w);
    wait_sig(0, 10, "t5_grant2", w);
    entry_req = 1'b0;
    check("t5_spacing", w, 5);
    @(negedge clk);
    check("t5_gate_cycle2", gate_open, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_parked", parked, 4'b0000);
    check("t5_empty", empty, 3'd4);
    check("t5_gate", gate_open, 1'b0);
    check("t5_full", full, 1'b0);

    // Back in IDLE: immediate service; mid-gate single-cycle requests are dropped.
    sb.push_back(ev(1'b1, 1'b0, 1'b0, 2'd0, 4'b0001));
    entry_req = 1'b1;
    wait_sig(0, 5, "t6_grant0", w);
    entry_req = 1'b0;
    check("t6_idle_lat", w, 1);
    @(negedge clk);
    entry_req = 1'b1;
    exit_req = 1'b1;
    exit_spot = 2'd0;
    @(negedge clk);
    entry_req = 1'b0;
    exit_req = 1'b0;
    repeat (8) @(negedge clk);
    check("t6_parked", parked, 4'b0001);
    check("t6_gate", gate_open, 1'b0);

    // A request raised mid-gate and held is served once the gate closes.
    sb.push_back(ev(1'b1, 1'b0, 1'b0, 2'd1, 4'b0011));
    entry_req = 1'b1;
    wait_sig(0, 5, "t6_grant1", w);
    entry_req = 1'b0;
    @(negedge clk);
    sb.push_back(ev(1'b1, 1'b0, 1'b0, 2'd2, 4'b0111));
    entry_req = 1'b1;
    wait_sig(0, 10, "t6_grant2", w);
    entry_req = 1'b0;
    check("t6_held_lat", w, 4);
    check("t6_empty", empty, 3'd1);

    repeat (6) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
